int2half_conv_engine: RTL and testbench

- Next-generation memory-mapped integer-to-float converter program block.
- Reads COUNT 16-bit sign-magnitude integers from data memory. Each integer is bit 15 = sign, bits 14:0 = magnitude.
- Normalises each one iteratively and writes a half-precision-style word to data memory: sign, 5-bit biased exponent, 10-bit mantissa.
- Adds a selectable round-to-nearest-even mode, a configurable bias and configurable buffer bases, plus a busy/done handshake.
- Sits beside the top-level program controller and drives the shared data_mem port.

---
 rtl/int2half_conv_engine.sv | 171 +++++++++++++++++
 tb/tb_int2half_conv_engine.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/int2half_conv_engine.sv
`default_nettype none
// ============================================================================
// Module   : int2half_conv_engine
// Brief    : Memory-mapped sign-magnitude int16 to half-precision converter.
// Revision : 1.0
// ============================================================================
module int2half_conv_engine #(
    parameter int AW       = 8,
    parameter int COUNT    = 1,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 2,
    parameter int BIAS     = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          round_en,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_CAP   = 3'd3,
        S_NORM  = 3'd4,
        S_PACK  = 3'd5,
        S_WR_LO = 3'd6,
        S_WR_HI = 3'd7
    } state_t;

    localparam logic [AW-1:0] c_src  = AW'(SRC_BASE);
    localparam logic [AW-1:0] c_dst  = AW'(DST_BASE);
    localparam logic [AW-1:0] c_last = AW'(COUNT - 1);
    localparam logic [AW-1:0] c_one  = AW'(1);
    localparam logic [5:0]    c_bias = 6'(BIAS);

    state_t        r_state;
    logic [AW-1:0] r_index;
    logic          r_rnd;
    logic [7:0]    r_lo;
    logic          r_sign;
    logic [14:0]   r_mag;
    logic [3:0]    r_p;
    logic          r_zero;
    logic [15:0]   r_result;

    // Address helpers; everything wraps modulo 2^AW.
    logic [AW-1:0] w_next_index;
    logic [AW-1:0] w_src_addr;
    logic [AW-1:0] w_src_next_addr;
    logic [AW-1:0] w_dst_addr;
    assign w_next_index    = r_index + c_one;
    assign w_src_addr      = c_src + {r_index[AW-2:0], 1'b0};
    assign w_src_next_addr = c_src + {w_next_index[AW-2:0], 1'b0};
    assign w_dst_addr      = c_dst + {r_index[AW-2:0], 1'b0};

    logic [14:0] w_cap_mag;
    assign w_cap_mag = {mem_rdata[6:0], r_lo};

    // Round-to-nearest-even on the normalised magnitude; a mantissa carry
    // leaves the low ten bits at zero and bumps the exponent.
    logic [9:0]  w_mant;
    logic        w_guard;
    logic        w_sticky;
    logic        w_inc;
    logic [10:0] w_mant_sum;
    logic [5:0]  w_exp;
    logic [15:0] w_result;
    assign w_mant     = r_mag[13:4];
    assign w_guard    = r_mag[3];
    assign w_sticky   = |r_mag[2:0];
    assign w_inc      = r_rnd & w_guard & (w_sticky | w_mant[0]);
    assign w_mant_sum = {1'b0, w_mant} + {10'd0, w_inc};
    assign w_exp      = c_bias + {2'b00, r_p} + {5'd0, w_mant_sum[10]};
    assign w_result   = r_zero ? {r_sign, 15'd0}
                               : {r_sign, w_exp[4:0], w_mant_sum[9:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_index   <= '0;
            r_rnd     <= 1'b0;
            r_lo      <= 8'd0;
            r_sign    <= 1'b0;
            r_mag     <= 15'd0;
            r_p       <= 4'd0;
            r_zero    <= 1'b0;
            r_result  <= 16'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rnd    <= round_en;
                        r_index  <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        mem_rd   <= 1'b1;
                        mem_addr <= c_src;
                        r_state  <= S_RD_LO;
                    end
                end
                S_RD_LO: begin
                    mem_addr <= w_src_addr + c_one;
                    r_state  <= S_RD_HI;
                end
                S_RD_HI: begin
                    r_lo    <= mem_rdata;
                    mem_rd  <= 1'b0;
                    r_state <= S_CAP;
                end
                S_CAP: begin
                    r_sign  <= mem_rdata[7];
                    r_mag   <= w_cap_mag;
                    r_p     <= 4'd14;
                    r_zero  <= (w_cap_mag == 15'd0);
                    r_state <= (w_cap_mag == 15'd0) ? S_PACK : S_NORM;
                end
                S_NORM: begin
                    // Nonzero magnitude guarantees termination within 14 shifts.
                    if (r_mag[14]) begin
                        r_state <= S_PACK;
                    end else begin
                        r_mag <= {r_mag[13:0], 1'b0};
                        r_p   <= r_p - 4'd1;
                    end
                end
                S_PACK: begin
                    r_result  <= w_result;
                    mem_wr    <= 1'b1;
                    mem_addr  <= w_dst_addr;
                    mem_wdata <= w_result[7:0];
                    r_state   <= S_WR_LO;
                end
                S_WR_LO: begin
                    mem_addr  <= w_dst_addr + c_one;
                    mem_wdata <= r_result[15:8];
                    r_state   <= S_WR_HI;
                end
                S_WR_HI: begin
                    mem_wr <= 1'b0;
                    if (r_index == c_last) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_index  <= w_next_index;
                        mem_rd   <= 1'b1;
                        mem_addr <= w_src_next_addr;
                        r_state  <= S_RD_LO;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int2half_conv_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_int2half_conv_engine
// Brief    : Directed self-checking bench for int2half_conv_engine.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_int2half_conv_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic       round_en = 1'b0;

    logic       busy1, done1, mem_rd1, mem_wr1;
    logic [7:0] mem_addr1, mem_wdata1;
    logic [7:0] mem_rdata1 = 8'd0;
    logic       busy2, done2, mem_rd2, mem_wr2;
    logic [7:0] mem_addr2, mem_wdata2;
    logic [7:0] mem_rdata2 = 8'd0;

    logic [7:0] mem1 [0:255];
    logic [7:0] mem2 [0:255];

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    int2half_conv_engine #(.AW(8), .COUNT(1), .SRC_BASE(0), .DST_BASE(2), .BIAS(15)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .round_en(round_en),
        .busy(busy1), .done(done1), .mem_addr(mem_addr1), .mem_rd(mem_rd1),
        .mem_wr(mem_wr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    int2half_conv_engine #(.AW(8), .COUNT(3), .SRC_BASE(16), .DST_BASE(32), .BIAS(15)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .round_en(round_en),
        .busy(busy2), .done(done2), .mem_addr(mem_addr2), .mem_rd(mem_rd2),
        .mem_wr(mem_wr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
    );

    // Synchronous-read memories
    always @(posedge clk) begin
        if (mem_wr1) mem1[mem_addr1] = mem_wdata1;
        if (mem_rd1) mem_rdata1 <= mem1[mem_addr1];
        if (mem_wr2) mem2[mem_addr2] = mem_wdata2;
        if (mem_rd2) mem_rdata2 <= mem2[mem_addr2];
    end

    always @(negedge clk) begin
        if ((mem_rd1 && mem_wr1) || (mem_rd2 && mem_wr2)) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_one(input logic [15:0] op, input logic rnd,
                           output logic [15:0] res, output int cyc, output logic busy_ok);
        @(negedge clk);
        mem1[0] = op[7:0];
        mem1[1] = op[15:8];
        mem1[2] = 8'hEE;
        mem1[3] = 8'hEE;
        round_en = rnd;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        round_en = ~rnd;
        cyc = 0;
        busy_ok = 1'b1;
        while (!done1 && cyc < 200) begin
            busy_ok &= busy1;
            @(posedge clk);
            #1 cyc++;
        end
        res = {mem1[3], mem1[2]};
    endtask

    task automatic run_three(input bit extra_start, output int cyc);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 400) begin
            @(posedge clk);
            #1 cyc++;
            start2 = (extra_start && cyc == 5);
        end
        start2 = 1'b0;
    endtask

    logic [15:0] res;
    int          cyc;
    logic        bok;
    bit          hit;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 8'h00;
            mem2[i] = 8'h00;
        end
        mem2[16] = 8'h01; mem2[17] = 8'h00;
        mem2[18] = 8'h00; mem2[19] = 8'h04;
        mem2[20] = 8'h00; mem2[21] = 8'h80;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  {31'd0, busy1}, 32'd0);
        check("rst_done",  {31'd0, done1}, 32'd0);
        check("rst_rd_wr", {30'd0, mem_rd1, mem_wr1}, 32'd0);
        check("rst_addr",  {24'd0, mem_addr1}, 32'd0);
        check("rst_wdata", {24'd0, mem_wdata1}, 32'd0);
        @(negedge clk) reset = 1'b0;

        run_one(16'h4000, 1'b0, res, cyc, bok);
        check("p16384_res", {16'd0, res}, 32'h7400);
        check("p16384_cyc", cyc, 7);
        check("p16384_busy", {31'd0, bok}, 32'd1);
        check("p16384_busy_off", {31'd0, busy1}, 32'd0);

        run_one(16'h8001, 1'b0, res, cyc, bok);
        check("m1_res", {16'd0, res}, 32'hBC00);
        check("m1_cyc", cyc, 21);

        run_one(16'h7FFF, 1'b0, res, cyc, bok);
        check("max_trunc", {16'd0, res}, 32'h77FF);
        run_one(16'h7FFF, 1'b1, res, cyc, bok);
        check("max_round", {16'd0, res}, 32'h7800);

        run_one(16'h4018, 1'b1, res, cyc, bok);
        check("rne_tie_odd", {16'd0, res}, 32'h7402);
        run_one(16'h4008, 1'b1, res, cyc, bok);
        check("rne_tie_even", {16'd0, res}, 32'h7400);
        run_one(16'h4009, 1'b1, res, cyc, bok);
        check("rne_sticky", {16'd0, res}, 32'h7401);
        run_one(16'h4018, 1'b0, res, cyc, bok);
        check("trunc_4018", {16'd0, res}, 32'h7401);

        run_one(16'h0000, 1'b1, res, cyc, bok);
        check("pzero_res", {16'd0, res}, 32'h0000);
        check("pzero_cyc", cyc, 6);
        run_one(16'h8000, 1'b1, res, cyc, bok);
        check("nzero_res", {16'd0, res}, 32'h8000);
        check("nzero_cyc", cyc, 6);
        check("done_held", {31'd0, done1}, 32'd1);

        // Three operands, with a redundant start while busy
        run_three(1'b1, cyc);
        check("c3_cyc", cyc, 38);
        check("c3_r0", {16'd0, mem2[33], mem2[32]}, 32'h3C00);
        check("c3_r1", {16'd0, mem2[35], mem2[34]}, 32'h6400);
        check("c3_r2", {16'd0, mem2[37], mem2[36]}, 32'h8000);

        // Abort during the high-byte write of operand 1
        for (int i = 32; i < 38; i++) mem2[i] = 8'hA5;
        @(negedge clk) start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (mem_wr2 && mem_addr2 == 8'h23) hit = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("abort_reached", {31'd0, hit}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("abort_wr", {31'd0, mem_wr2}, 32'd0);
        check("abort_busy_done", {30'd0, busy2, done2}, 32'd0);
        check("abort_addr", {24'd0, mem_addr2}, 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_hi_kept", {24'd0, mem2[35]}, 32'hA5);
        check("abort_lo_written", {24'd0, mem2[34]}, 32'h00);
        check("abort_idle", {30'd0, busy2, done2}, 32'd0);

        run_three(1'b0, cyc);
        check("rerun_cyc", cyc, 38);
        check("rerun_r0", {16'd0, mem2[33], mem2[32]}, 32'h3C00);
        check("rerun_r1", {16'd0, mem2[35], mem2[34]}, 32'h6400);
        check("rerun_r2", {16'd0, mem2[37], mem2[36]}, 32'h8000);

        check("rd_wr_exclusive", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
